// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: pipelined RV32I control unit, decodes in D and carries the control bundle through E/M/W
//
// Ports:
//   clk, reset (async, active-low)
//   D inputs    : op, funct3, funct7b5, ValidD
//   E controls  : StallE (hold E, bubble into M), FlushE (bubble into E, wins over StallE)
//   ALU flags   : ZeroE, LtE, LtuE
//   D outputs   : ImmSrcD, IllegalD (combinational)
//   E outputs   : ALUControlE, ALUSrcAE, ALUSrcBE, ResultSrcE, PCSrcE, PCTargetSrcE
//   M outputs   : MemWriteM, RegWriteM
//   W outputs   : RegWriteW, ResultSrcW
//   RetireCnt   : retired-instruction count, only when CTRL_RETIRE_CNT_EN is defined
//
// Optional feature macro: CTRL_RETIRE_CNT_EN
module rv_pipe_ctrl #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 ValidD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ResultSrcW,
    output logic                 PCSrcE,
    output logic                 PCTargetSrcE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]     RetireCnt
`endif
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] funct3;
        logic [3:0] alu;
        logic [1:0] src_a;
        logic       src_b;
        logic       pc_tgt;
        logic       valid;
    } e_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       valid;
    } m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       valid;
    } w_t;

    e_t         d_b, e;
    m_t         m;
    w_t         w;
    logic [3:0] alu_op;
    logic       known;
    logic       br_base, br_ok;

    // sub is R-type only (I-type bit 30 is immediate data); sra applies to both
    always_comb begin
        case (funct3)
            3'b000:  alu_op = (op == OP_R && funct7b5) ? 4'd1 : 4'd0;
            3'b001:  alu_op = 4'd7;
            3'b010:  alu_op = 4'd5;
            3'b011:  alu_op = 4'd6;
            3'b100:  alu_op = 4'd4;
            3'b101:  alu_op = funct7b5 ? 4'd9 : 4'd8;
            3'b110:  alu_op = 4'd3;
            default: alu_op = 4'd2;
        endcase
    end

    always_comb begin
        d_b        = '0;
        ImmSrcD    = 3'b000;
        known      = 1'b1;
        d_b.funct3 = funct3;
        d_b.valid  = 1'b1;
        case (op)
            OP_LW: begin
                d_b.reg_write  = 1'b1;
                d_b.result_src = 2'b01;
                d_b.src_b      = 1'b1;
            end
            OP_SW: begin
                ImmSrcD       = 3'b001;
                d_b.mem_write = 1'b1;
                d_b.src_b     = 1'b1;
            end
            OP_R: begin
                d_b.reg_write = 1'b1;
                d_b.alu       = alu_op;
            end
            OP_I: begin
                d_b.reg_write = 1'b1;
                d_b.alu       = alu_op;
                d_b.src_b     = 1'b1;
            end
            OP_BR: begin
                ImmSrcD    = 3'b010;
                d_b.branch = 1'b1;
                d_b.alu    = 4'd1;
            end
            OP_JAL: begin
                ImmSrcD        = 3'b011;
                d_b.reg_write  = 1'b1;
                d_b.jump       = 1'b1;
                d_b.result_src = 2'b10;
            end
            OP_JALR: begin
                d_b.reg_write  = 1'b1;
                d_b.jump       = 1'b1;
                d_b.result_src = 2'b10;
                d_b.src_b      = 1'b1;
                d_b.pc_tgt     = 1'b1;
            end
            OP_LUI: begin
                ImmSrcD       = 3'b100;
                d_b.reg_write = 1'b1;
                d_b.src_a     = 2'b10;
                d_b.src_b     = 1'b1;
            end
            OP_AUIPC: begin
                ImmSrcD       = 3'b100;
                d_b.reg_write = 1'b1;
                d_b.src_a     = 2'b01;
                d_b.src_b     = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // invalid slots and unrecognised opcodes both travel as an all-zero bubble
        if (!(ValidD && known))
            d_b = '0;
        IllegalD = ValidD & ~known;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e <= '0;
            m <= '0;
            w <= '0;
        end else begin
            e <= FlushE ? '0 : StallE ? e : d_b;
            m <= (StallE && !FlushE) ? '0 : {e.reg_write, e.result_src, e.mem_write, e.valid};
            w <= {m.reg_write, m.result_src, m.valid};
        end
    end

    // funct3[2:1] picks the flag (00 Zero, 10 Lt, 11 Ltu), funct3[0] inverts; 01x never taken
    assign br_base = (e.funct3[2:1] == 2'b00) ? ZeroE :
                     (e.funct3[2:1] == 2'b10) ? LtE   :
                     (e.funct3[2:1] == 2'b11) ? LtuE  : 1'b0;
    assign br_ok   = (e.funct3[2:1] != 2'b01) & (br_base ^ e.funct3[0]);

    assign PCSrcE       = e.valid & (e.jump | (e.branch & br_ok));
    assign ALUControlE  = ALUCTRL_W'(e.alu);
    assign ALUSrcAE     = e.src_a;
    assign ALUSrcBE     = e.src_b;
    assign ResultSrcE   = e.result_src;
    assign PCTargetSrcE = e.pc_tgt;
    assign MemWriteM    = m.mem_write;
    assign RegWriteM    = m.reg_write;
    assign RegWriteW    = w.reg_write;
    assign ResultSrcW   = w.result_src;

`ifdef CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            RetireCnt <= '0;
        else if (w.valid)
            RetireCnt <= RetireCnt + CNT_W'(1);
    end
`else
    logic unused_valid_w;
    assign unused_valid_w = w.valid;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: directed self-checking bench for rv_pipe_ctrl
module tb_rv_pipe_ctrl;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0, ValidD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
    logic       ZeroE = 1'b0, LtE = 1'b0, LtuE = 1'b0;
    logic [2:0] ImmSrcD;
    logic       IllegalD, ALUSrcBE, PCSrcE, PCTargetSrcE, MemWriteM, RegWriteM, RegWriteW;
    logic [3:0] ALUControlE;
    logic [1:0] ALUSrcAE, ResultSrcE, ResultSrcW;
`ifdef CTRL_RETIRE_CNT_EN
    logic [3:0] RetireCnt;
`endif

    int total = 0;
    int bad = 0;

    rv_pipe_ctrl #(.ALUCTRL_W(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
        .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .ResultSrcW(ResultSrcW), .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW)
`ifdef CTRL_RETIRE_CNT_EN
        , .RetireCnt(RetireCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic v);
        op = o;
        funct3 = f;
        funct7b5 = f7;
        ValidD = v;
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pcsrc", PCSrcE, 0);
        chk("rst_memw", MemWriteM, 0);
        chk("rst_regwm", RegWriteM, 0);
        chk("rst_regww", RegWriteW, 0);
        chk("rst_alu", ALUControlE, 0);
        chk("rst_ressrcw", ResultSrcW, 0);
`ifdef CTRL_RETIRE_CNT_EN
        chk("rst_cnt", RetireCnt, 0);
`endif
        @(negedge clk) reset = 1'b1;
        tick();
        // lw through the pipe
        setd(LW, 3'b010, 1'b0, 1'b1);
        chk("lw_imm", ImmSrcD, 3'b000);
        chk("lw_ill", IllegalD, 0);
        tick();
        chk("lw_alu", ALUControlE, 0);
        chk("lw_srcb", ALUSrcBE, 1);
        chk("lw_res_e", ResultSrcE, 2'b01);
        setd(LW, 3'b010, 1'b0, 1'b0);
        tick();
        chk("lw_regwm", RegWriteM, 1);
        chk("lw_regww_early", RegWriteW, 0);
        tick();
        chk("lw_regww", RegWriteW, 1);
        chk("lw_res_w", ResultSrcW, 2'b01);
        // ALU decode corners
        setd(RT, 3'b000, 1'b1, 1'b1); tick(); chk("sub", ALUControlE, 1);
        setd(IT, 3'b000, 1'b1, 1'b1); tick(); chk("addi_b30", ALUControlE, 0);
        setd(IT, 3'b101, 1'b1, 1'b1); tick(); chk("srai", ALUControlE, 9);
        setd(RT, 3'b101, 1'b0, 1'b1); tick(); chk("srl", ALUControlE, 8);
        setd(RT, 3'b011, 1'b0, 1'b1); tick(); chk("sltu", ALUControlE, 6);
        setd(RT, 3'b100, 1'b0, 1'b1); tick(); chk("xor", ALUControlE, 4);
        // branches
        ZeroE = 1'b0;
        setd(BR, 3'b001, 1'b0, 1'b1);
        chk("br_imm", ImmSrcD, 3'b010);
        tick();
        chk("br_alu", ALUControlE, 1);
        chk("bne_taken", PCSrcE, 1);
        ZeroE = 1'b1; #1;
        chk("bne_zero", PCSrcE, 0);
        setd(BR, 3'b111, 1'b0, 1'b1);
        LtuE = 1'b1;
        tick();
        chk("bgeu_ltu", PCSrcE, 0);
        LtuE = 1'b0; #1;
        chk("bgeu_ge", PCSrcE, 1);
        ZeroE = 1'b0;
        setd(BR, 3'b011, 1'b0, 1'b1); tick(); chk("br_011", PCSrcE, 0);
        LtE = 1'b1;
        setd(BR, 3'b100, 1'b0, 1'b1); tick(); chk("blt", PCSrcE, 1);
        LtE = 1'b0;
        // jalr and U-type
        setd(JALR, 3'b000, 1'b0, 1'b1);
        tick();
        chk("jalr_pcsrc", PCSrcE, 1);
        chk("jalr_tgt", PCTargetSrcE, 1);
        setd(JALR, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        chk("jalr_res_w", ResultSrcW, 2'b10);
        chk("jalr_regww", RegWriteW, 1);
        setd(LUI, 3'b000, 1'b0, 1'b1);
        chk("lui_imm", ImmSrcD, 3'b100);
        tick();
        chk("lui_srca", ALUSrcAE, 2'b10);
        chk("lui_pcsrc", PCSrcE, 0);
        setd(AUIPC, 3'b000, 1'b0, 1'b1); tick(); chk("auipc_srca", ALUSrcAE, 2'b01);
        // stall holding sw in E
        setd(SW, 3'b010, 1'b0, 1'b1);
        chk("sw_imm", ImmSrcD, 3'b001);
        tick();
        setd(SW, 3'b010, 1'b0, 1'b0);
        StallE = 1'b1;
        tick(); chk("stall1_memw", MemWriteM, 0);
        tick(); chk("stall2_memw", MemWriteM, 0);
        StallE = 1'b0;
        tick(); chk("sw_memw", MemWriteM, 1);
        tick(); chk("sw_memw_once", MemWriteM, 0);
        // flush overrides stall
        setd(IT, 3'b000, 1'b0, 1'b1);
        tick();
        chk("pre_flush_srcb", ALUSrcBE, 1);
        setd(IT, 3'b000, 1'b0, 1'b0);
        FlushE = 1'b1;
        StallE = 1'b1;
        tick();
        chk("flush_e_srcb", ALUSrcBE, 0);
        chk("flush_m_regw", RegWriteM, 1);
        FlushE = 1'b0;
        StallE = 1'b0;
        // illegal opcode
        setd(7'h7f, 3'b000, 1'b0, 1'b1);
        chk("ill_flag", IllegalD, 1);
        tick();
        chk("ill_pcsrc", PCSrcE, 0);
        setd(7'h7f, 3'b000, 1'b0, 1'b0);
        chk("ill_novalid", IllegalD, 0);
        tick();
        chk("ill_regwm", RegWriteM, 0);
        chk("ill_memw", MemWriteM, 0);
        tick();
        chk("ill_regww", RegWriteW, 0);
        // asynchronous reset mid-run
        setd(LW, 3'b010, 1'b0, 1'b1);
        tick();
        setd(LW, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_rst_regww", RegWriteW, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_regww", RegWriteW, 0);
        chk("async_res_w", ResultSrcW, 0);
`ifdef CTRL_RETIRE_CNT_EN
        chk("async_cnt", RetireCnt, 0);
`endif
        @(negedge clk) reset = 1'b1;
`ifdef CTRL_RETIRE_CNT_EN
        setd(LW, 3'b010, 1'b0, 1'b1);
        repeat (17) tick();
        setd(LW, 3'b010, 1'b0, 1'b0);
        repeat (2) tick();
        chk("cnt_16", RetireCnt, 0);
        tick();
        chk("cnt_wrap", RetireCnt, 1);
        setd(LW, 3'b010, 1'b0, 1'b1);
        repeat (5) tick();
        chk("cnt_run", RetireCnt, 3);
        #2 reset = 1'b0;
        #1;
        chk("cnt_async", RetireCnt, 0);
        @(negedge clk) reset = 1'b1;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_pipe_ctrl.md
# rv_pipe_ctrl

- Parametrised pipelined control unit for the five-stage RV32I core.
- Decodes the instruction in Decode (D) and carries the control bundle through Execute (E), Memory (M) and Writeback (W) registers.
- Adds full RV32I conditional branches, jalr, lui, auipc, shifts/xor/sltu, an E-stage stall, explicit valid tracking and an optional retired-instruction counter.
- Sits between the instruction decode fields and the datapath muxes, ALU and hazard unit.

## Interface
Parameters:
- ALUCTRL_W, default 4: ALUControl width, must be ≥4; bits above [3] are driven 0.
- CNT_W, default 32: retire counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op  in  7  instruction [6:0], D stage.
- funct3  in  3  instruction [14:12], D stage.
- funct7b5  in  1  instruction [30], D stage.
- ValidD  in  1  D holds a real instruction.
- StallE  in  1  hold E register.
- FlushE  in  1  load bubble into E.
- ZeroE, LtE, LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- IllegalD  out  1  op unrecognised while ValidD=1.
- ALUControlE  out  ALUCTRL_W  operation code (see Operation).
- ALUSrcAE  out  2  00 rs1, 01 PC, 10 zero.
- ALUSrcBE  out  1  0 rs2, 1 immediate.
- ResultSrcE, ResultSrcW  out  2 each  00 ALU, 01 memory, 10 PC+4.
- PCSrcE  out  1  take branch/jump.
- PCTargetSrcE  out  1  0 PC+imm, 1 ALU result (jalr).
- MemWriteM  out  1  store enable.
- RegWriteM, RegWriteW  out  1 each  register-file write.
- RetireCnt  out  CNT_W  retired instructions; present only with the macro.

## Operation
- D decode is combinational:
  - lw: I, add, srcB imm, result mem.
  - sw: S, add, MemWrite.
  - R-type and I-ALU: ALU per funct3/funct7b5.
  - Branch (1100011): B, sub, Branch.
  - jal: J, Jump, result PC+4.
  - jalr: I, add, srcB imm, Jump, PCTargetSrc=1, result PC+4.
  - lui: U, srcA zero, add.
  - auipc: U, srcA PC, add.
- ALU codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
  - sub applies only for R-type funct3=000 with funct7b5=1.
  - sra is selected by funct3=101 with funct7b5=1, for R-type and I-type.
- Unknown op: IllegalD=1 and the bundle is decoded as a bubble (all write/branch/jump enables 0, Valid 0).
- Bundle per stage:
  - E holds RegWrite, ResultSrc, MemWrite, Jump, Branch, funct3, ALUControl, ALUSrcA, ALUSrcB, PCTargetSrc, Valid.
  - M holds RegWrite, ResultSrc, MemWrite, Valid.
  - W holds RegWrite, ResultSrc, Valid.
- Branch condition by funct3 of E:
  - 000 Zero, 001 !Zero.
  - 100 Lt, 101 !Lt.
  - 110 Ltu, 111 !Ltu.
  - 010/011 never taken.
- PCSrcE = ValidE & (JumpE | (BranchE & cond)).
- Bubble means all register fields 0.

## Timing
- Reset: every E/M/W field and every registered output is 0, so PCSrcE, MemWriteM, RegWriteM and RegWriteW are all 0. RetireCnt is 0.
- Latency: a D instruction appears in E 1 cycle later, in M after 2 cycles and in W after 3 cycles. ImmSrcD and IllegalD have zero latency.
- Stage register priority per edge:
  - FlushE=1: E loads bubble; M loads E as usual. FlushE overrides StallE.
  - StallE=1 (no flush): E holds its value and M loads a bubble.
  - W always loads M.
- ValidD=0 decodes to a bubble regardless of op.
- Reset mid-operation clears all stages immediately (asynchronous). Release is synchronous to the next rising edge.

## Configuration
- CTRL_RETIRE_CNT_EN defined:
  - RetireCnt port exists.
  - The counter increments by 1 on each edge where ValidW=1, and wraps from 2^CNT_W−1 to 0.
- CTRL_RETIRE_CNT_EN undefined: no port and no counter logic.

## Test plan
- Reset low, then release; issue lw (op 0000011) with ValidD=1 → E shows ALUControl 0, ALUSrcB 1, ResultSrc 01; RegWriteW=1 exactly 3 cycles after issue.
- bne (funct3 001) with ZeroE=0 → PCSrcE=1 in E. Same with ZeroE=1 → 0. bgeu with LtuE=1 → 0.
- jalr → PCSrcE=1, PCTargetSrcE=1, ResultSrcW=10. lui → ALUSrcAE=10, ImmSrcD=100.
- StallE=1 for 2 cycles holding sw → MemWriteM=0 for those 2 cycles, then 1 for one cycle. FlushE=StallE=1 → E becomes bubble.
- op 1111111 with ValidD=1 → IllegalD=1 and no RegWrite/MemWrite downstream.
- Macro on, CNT_W=4: 17 back-to-back valid instructions → RetireCnt wraps to 1. Asserting reset mid-run → 0 immediately.
